// File: rtl/yarvi_alu_seq.sv
// yarvi_alu_seq: RV32I integer ALU with an iterative shifter.
// Non-shift ops finish in one cycle. Shifts walk SHIFT_STEP bits per
// cycle through a single shifter. One result is held in DONE until the
// consumer takes it.
module yarvi_alu_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_insn30,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [4:0]  req_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_tag,
  input  logic        flush,
  output logic        busy
);

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_result;
  logic [4:0]  r_tag;
  logic [5:0]  r_cnt;
  logic        r_left;
  logic        r_arith;

  logic        w_accept;
  logic        w_is_shift;
  logic [31:0] w_alu;
  logic [5:0]  w_step;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] w_shifted;

  // Single-cycle evaluation of all ops. Shifts only come through here
  // with a zero amount, which returns op1 unchanged.
  function automatic logic [31:0] alu_eval(input logic [2:0] f3, input logic i30,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    res = 32'd0;
    case (f3)
      3'd0: res = i30 ? (a - b) : (a + b);
      3'd1: res = a << b[4:0];
      3'd2: res = {31'd0, ($signed(a) < $signed(b))};
      3'd3: res = {31'd0, (a < b)};
      3'd4: res = a ^ b;
      3'd5: res = i30 ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  assign w_accept   = req_valid & req_ready;
  assign w_is_shift = ((req_funct3 == 3'd1) || (req_funct3 == 3'd5)) && (req_op2[4:0] != 5'd0);
  assign w_alu      = alu_eval(req_funct3, req_insn30, req_op1, req_op2);
  assign w_step     = (r_cnt < STEP) ? r_cnt : STEP;
  assign w_cnt_nxt  = r_cnt - w_step;

  assign rsp_result = r_result;
  assign rsp_tag    = r_tag;

  // One partial shift step. For SRA the sign bit stays in bit 31 of the
  // working value, so an arithmetic shift keeps filling with the original sign.
  always_comb begin
    w_shifted = r_result;
    if (r_left)       w_shifted = r_result << w_step;
    else if (r_arith) w_shifted = 32'($signed(r_result) >>> w_step);
    else              w_shifted = r_result >> w_step;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake outputs. While reset is asserted req_ready is held low.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        req_ready = reset_n & ~flush;
        if (w_accept) w_state_nxt = w_is_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_cnt_nxt == 6'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        req_ready = reset_n & ~flush & rsp_ready;
        if (rsp_ready) begin
          if (w_accept) w_state_nxt = w_is_shift ? S_SHIFT : S_DONE;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Result, tag and shifter state. Loaded only on acceptance; this keeps
  // the DONE outputs stable and isolates in-flight work from the request bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= 32'd0;
      r_tag    <= 5'd0;
      r_cnt    <= 6'd0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
    end else if (flush) begin
      r_cnt    <= 6'd0;
    end else if (w_accept) begin
      r_tag <= req_tag;
      if (w_is_shift) begin
        r_result <= req_op1;
        r_cnt    <= {1'b0, req_op2[4:0]};
        r_left   <= (req_funct3 == 3'd1);
        r_arith  <= req_insn30;
      end else begin
        r_result <= w_alu;
        r_cnt    <= 6'd0;
      end
    end else if (r_state == S_SHIFT) begin
      r_result <= w_shifted;
      r_cnt    <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_yarvi_alu_seq.sv
// Bench for yarvi_alu_seq: directed cases plus randomized traffic. A
// scoreboard queue holds the expected responses and a negedge monitor
// checks each one as it is handed over.
module tb_yarvi_alu_seq;

  localparam int STEP = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_insn30 = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_op1 = 32'd0;
  logic [31:0] req_op2 = 32'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        flush = 1'b0;
  logic        busy;

  logic rr_rand  = 1'b0;
  logic rr_fixed = 1'b1;
  logic rr_rnd   = 1'b1;
  assign rsp_ready = rr_rand ? rr_rnd : rr_fixed;

  int n_vec = 0;
  int n_mis = 0;
  logic [36:0] exp_q[$];

  yarvi_alu_seq #(.SHIFT_STEP(STEP)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_insn30(req_insn30), .req_funct3(req_funct3), .req_op1(req_op1),
    .req_op2(req_op2), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag),
    .flush(flush), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      rr_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model. Shifts are expressed as multiplication or as a
  // right shift of a 64-bit sign/zero-extended value.
  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic i30,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    logic [31:0] p;
    int s;
    s = int'(b[4:0]);
    p = 32'd1 << s;
    ext = {{32{i30 & a[31]}}, a} >> s;
    case (f)
      3'd0: return i30 ? a - b : a + b;
      3'd1: return a * p;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return ext[31:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    if ((f == 3'd1 || f == 3'd5) && s != 0) return 1 + (s + STEP - 1) / STEP;
    return 1;
  endfunction

  // Present a request, wait until it is taken, record the expectation, then
  // scramble the request bus so late changes would show up as errors.
  task automatic issue_nowait(input logic [2:0] f, input logic i30, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag, output int waits);
    req_funct3 = f; req_insn30 = i30; req_op1 = a; req_op2 = b; req_tag = tag;
    req_valid = 1'b1;
    waits = 0;
    @(negedge clock);
    while (!req_ready && waits < 100) begin
      @(posedge clock); #1; waits++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_vec++; n_mis++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", waits);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    exp_q.push_back({tag, ref_alu(f, i30, a, b)});
    #1;
    req_valid  = 1'b0;
    req_op1    = $urandom;
    req_op2    = $urandom;
    req_funct3 = 3'($urandom);
    req_insn30 = 1'($urandom);
    req_tag    = 5'($urandom);
  endtask

  task automatic issue_lat(input string name, input logic [2:0] f, input logic i30,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int waits;
    int lat;
    issue_nowait(f, i30, a, b, tag, waits);
    lat = 1;
    @(negedge clock);
    while (!rsp_valid && lat < 100) begin
      @(posedge clock); lat++;
      @(negedge clock);
    end
    check32({name, "_latency"}, 32'(lat), 32'(ref_lat(f, b)));
    @(posedge clock); #1;
  endtask

  // Monitor: result/tag stable while stalled, and each handshake matches the queue.
  logic        prev_hold = 1'b0;
  logic [36:0] prev_val = 37'd0;
  always @(negedge clock) begin
    logic [36:0] e;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (rsp_valid && prev_hold)
        check32("hold_stable", {rsp_tag, rsp_result} ^ prev_val, 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_rsp: got result 0x%08h tag %0d, required no response",
                   rsp_result, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          check32("rsp_result", rsp_result, e[31:0]);
          check32("rsp_tag", {27'd0, rsp_tag}, {27'd0, e[36:32]});
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_val  = {rsp_tag, rsp_result};
    end
  end

  initial begin
    int waits;
    int cnt;
    logic [2:0]  f;
    logic [31:0] a, b;

    repeat (3) @(posedge clock);
    #1;
    check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("reset_result", rsp_result, 32'd0);
    check32("reset_tag", {27'd0, rsp_tag}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check32("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    flush = 1'b1;
    #1;
    check32("flush_blocks_ready", {31'd0, req_ready}, 32'd0);
    flush = 1'b0;

    issue_lat("add",  3'd0, 1'b0, 32'd5, 32'd7, 5'd3);
    issue_lat("sub",  3'd0, 1'b1, 32'd5, 32'd7, 5'd4);
    issue_lat("sra31", 3'd5, 1'b1, 32'h8000_0000, 32'd31, 5'd10);
    issue_lat("srl31", 3'd5, 1'b0, 32'h8000_0000, 32'd31, 5'd11);
    issue_lat("sll9", 3'd1, 1'b0, 32'h1, 32'd9, 5'd12);
    issue_lat("sll0", 3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 5'd13);
    issue_lat("slt",  3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd14);
    issue_lat("sltu", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd15);
    issue_lat("xor",  3'd4, 1'b1, 32'hA5A5_0F0F, 32'hFFFF_0000, 5'd16);
    issue_lat("and",  3'd7, 1'b1, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5'd17);

    // Consumer stalls for five DONE cycles, then takes the result while a new op arrives.
    rr_fixed = 1'b0;
    issue_lat("stall_add", 3'd0, 1'b0, 32'h11, 32'h22, 5'd5);
    repeat (4) begin
      @(negedge clock);
      check32("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check32("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check32("stall_result", rsp_result, 32'h33);
      check32("stall_tag", {27'd0, rsp_tag}, 32'd5);
      @(posedge clock); #1;
    end
    rr_fixed = 1'b1;
    issue_nowait(3'd6, 1'b0, 32'hF0, 32'h0F, 5'd6, waits);
    check32("b2b_waits", 32'(waits), 32'd0);
    @(negedge clock);
    check32("b2b_valid", {31'd0, rsp_valid}, 32'd1);
    check32("b2b_result", rsp_result, 32'h0000_00FF);
    @(posedge clock); #1;

    // Flush in the third SHIFT cycle of a 31-bit shift.
    issue_nowait(3'd5, 1'b1, 32'h8000_0000, 32'd31, 5'd7, waits);
    @(posedge clock); #1;
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    check32("flush_busy_before", {31'd0, busy}, 32'd1);
    check32("flush_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (rsp_valid) cnt++;
    end
    check32("flush_no_valid", 32'(cnt), 32'd0);
    check32("flush_busy_after", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    issue_lat("after_flush", 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd8);

    // Asynchronous reset in the middle of a shift.
    issue_nowait(3'd1, 1'b0, 32'h1, 32'd31, 5'd9, waits);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check32("midreset_valid", {31'd0, rsp_valid}, 32'd0);
    check32("midreset_result", rsp_result, 32'd0);
    check32("midreset_tag", {27'd0, rsp_tag}, 32'd0);
    check32("midreset_busy", {31'd0, busy}, 32'd0);
    check32("midreset_ready", {31'd0, req_ready}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check32("midreset_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;

    // Randomized traffic with a randomly stalling consumer.
    rr_rand = 1'b1;
    repeat (300) begin
      f = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31));
      issue_nowait(f, 1'($urandom), a, b, 5'($urandom), waits);
    end
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(posedge clock); cnt++;
    end
    check32("drain_left", 32'(exp_q.size()), 32'd0);
    rr_rand = 1'b0;
    @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/yarvi_alu_seq.md
YARVI_ALU_SEQ -- requirements
Module: yarvi_alu_seq

Interface
REQ-001 SHALL have parameter: SHIFT_STEP, 1, max bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port: clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  request present.
REQ-005 SHALL have port: req_ready  out  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have port: req_insn30  in  1  SUB for ADDSUB, arithmetic for SR.
REQ-007 SHALL have port: req_funct3  in  3  operation select.
REQ-008 SHALL have port: req_op1  in  32  operand 1.
REQ-009 SHALL have port: req_op2  in  32  operand 2; bits [4:0] are the shift amount.
REQ-010 SHALL have port: req_tag  in  5  destination tag, returned unchanged.
REQ-011 SHALL have port: rsp_valid  out  1  result present.
REQ-012 SHALL have port: rsp_ready  in  1  consumer takes result when rsp_valid & rsp_ready.
REQ-013 SHALL have port: rsp_result  out  32  result.
REQ-014 SHALL have port: rsp_tag  out  5  tag of the result.
REQ-015 SHALL have port: flush  in  1  synchronous kill of any in-flight operation.
REQ-016 SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-017 SHALL implement funct3 encodings: 0 ADD/SUB (insn30=1 subtracts), 1 SLL, 2 SLT signed, 3 SLTU, 4 XOR, 5 SRL/SRA (insn30=1 arithmetic), 6 OR, 7 AND; insn30 is ignored for other codes.
REQ-018 SHALL compute all arithmetic modulo 2^32; SLT/SLTU SHALL return 0 or 1 zero-extended.
REQ-019 SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-020 SHALL drive req_ready = ~flush & (IDLE | (DONE & rsp_ready)); req_ready is combinational from rsp_ready.
REQ-021 On acceptance of a non-shift op, or of a shift with shamt 0, SHALL register the result and tag and enter DONE; rsp_valid is high the next cycle (latency 1).
REQ-022 On acceptance of a shift with shamt s>0, SHALL load op1, s and direction, then enter SHIFT.
REQ-023 In SHIFT, each cycle SHALL shift by min(remaining, SHIFT_STEP) and decrement the remaining count by the same amount; SRA SHALL fill with bit 31 of the original op1.
REQ-024 SHALL leave SHIFT for DONE in the cycle the remaining count reaches 0; total latency is 1+ceil(s/SHIFT_STEP) cycles.
REQ-025 In DONE, rsp_valid SHALL be 1, and rsp_result/rsp_tag SHALL be held stable until the handshake completes.
REQ-026 In DONE with rsp_ready=1: if req_valid=1, SHALL accept the new request in the same cycle (back-to-back) and follow REQ-021/022; otherwise SHALL go to IDLE.
REQ-027 rsp_valid SHALL be 0 in IDLE and SHIFT.
REQ-028 flush=1 SHALL take priority over all other events: the next state is IDLE, rsp_valid is 0 next cycle, and nothing is accepted that cycle; rsp_result/rsp_tag values after a flush are don't-care.
REQ-029 Request inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect an in-flight operation.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, rsp_valid=0, rsp_result=0, rsp_tag=0, busy=0, shift count=0, and req_ready=0, including mid-SHIFT.
REQ-031 After reset_n deassertion, req_ready SHALL be 1 in the first cycle unless flush=1.

Verification
REQ-032 ADD 5+7 tag 3 accepted at cycle 0 -> rsp_valid at cycle 1, result 0x0000000C, tag 3; SUB 5-7 -> 0xFFFFFFFE.
REQ-033 SHIFT_STEP=1, SRA 0x80000000 by 31 -> busy for 32 cycles, rsp_valid at cycle 32, result 0xFFFFFFFF; SRL of the same operands -> 0x00000001.
REQ-034 SHIFT_STEP=4, SLL 0x1 by 9 -> 3 SHIFT cycles, rsp_valid at cycle 4, result 0x00000200; SLL by 0 -> rsp_valid at cycle 1, result = op1.
REQ-035 rsp_ready held low for 5 cycles in DONE -> result and tag stable, req_ready=0; then rsp_ready=1 with req_valid=1 (OR 0xF0|0x0F) -> rsp_valid stays high next cycle with 0x000000FF.
REQ-036 flush asserted at SHIFT cycle 3 of a 31-bit shift -> IDLE next cycle, no rsp_valid pulse; reset_n low mid-SHIFT -> all outputs 0 in the same cycle.
REQ-037 SLT 0xFFFFFFFF vs 0x1 -> 1; SLTU of the same operands -> 0.
